// File: rtl/fft32_stage_ctrl.sv
// Stage sequencer for the 32-point radix-2 DIT FFT butterfly array.
// Optional per-stage 1/2 scaling request: define FFT_STAGE_SCALE_EN.
module fft32_stage_ctrl #(
    parameter  int LOG2N    = 5,
    parameter  int TW_AW    = 4,
    parameter  int BFLY_LAT = 1,
    localparam int NB       = 2 ** (LOG2N - 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                ready,
    input  logic                abort,
    output logic                bf_en,
    output logic                wr_en,
    output logic [2:0]          stage,
    output logic                buf_sel,
    output logic [NB*TW_AW-1:0] tw_addr,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                scale_en
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [2:0] LAST = 3'(LOG2N - 1);
    localparam logic [2:0] LAT  = 3'(BFLY_LAT);

    state_t              state_q, state_d;
    logic [2:0]          stage_q, stage_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                buf_sel_q, buf_sel_d;
    logic [NB*TW_AW-1:0] tw_q, tw_d;

    // DIT twiddle index: (k mod 2^s) scaled up to the W_N^k grid
    function automatic logic [TW_AW-1:0] tw_calc(
        input int         k,
        input logic [2:0] s
    );
        logic [TW_AW-1:0] kk;
        logic [TW_AW-1:0] mask;
        kk   = TW_AW'(k);
        mask = TW_AW'((1 << s) - 1);
        return (kk & mask) << (TW_AW - int'(s));
    endfunction

    // Next-state, stage/bank bookkeeping and strobes
    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        cnt_d     = cnt_q;
        buf_sel_d = buf_sel_q;
        bf_en     = 1'b0;
        wr_en     = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    stage_d   = 3'd0;
                    buf_sel_d = 1'b0;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                bf_en   = 1'b1;
                cnt_d   = LAT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    wr_en     = 1'b1;
                    buf_sel_d = ~buf_sel_q;
                    if (stage_q == LAST) begin
                        state_d = S_DONE;
                    end else begin
                        stage_d = stage_q + 3'd1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // cancel freezes stage and bank, only the sequencer returns home
        if (abort) begin
            state_d   = S_IDLE;
            stage_d   = stage_q;
            buf_sel_d = buf_sel_q;
            cnt_d     = 3'd0;
        end
    end

    // Twiddle addresses follow the next stage so they change with it
    always_comb begin
        tw_d = '0;
        for (int k = 0; k < NB; k++) begin
            tw_d[k*TW_AW +: TW_AW] = tw_calc(k, stage_d);
        end
    end

    // Sequencer state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            stage_q   <= 3'd0;
            cnt_q     <= 3'd0;
            buf_sel_q <= 1'b0;
            tw_q      <= '0;
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            cnt_q     <= cnt_d;
            buf_sel_q <= buf_sel_d;
            tw_q      <= tw_d;
        end
    end

    assign ready   = (state_q == S_IDLE);
    assign busy    = (state_q != S_IDLE);
    assign stage   = stage_q;
    assign buf_sel = buf_sel_q;
    assign tw_addr = tw_q;

`ifdef FFT_STAGE_SCALE_EN
    assign scale_en = (state_q == S_ISSUE) ||
                      (state_q == S_WAIT);
`else
    assign scale_en = 1'b0;
`endif

endmodule

// File: tb/tb_fft32_stage_ctrl.sv
// Self-checking bench for fft32_stage_ctrl.
// Two instances: BFLY_LAT = 1 (u1) and BFLY_LAT = 3 (u3).
module tb_fft32_stage_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        start1 = 0, abort1 = 0, ordy1 = 0;
    logic        ready1, bf1, wr1, bs1, busy1, ov1, sc1;
    logic [2:0]  stage1;
    logic [63:0] tw1;

    logic        start3 = 0, abort3 = 0, ordy3 = 0;
    logic        ready3, bf3, wr3, bs3, busy3, ov3, sc3;
    logic [2:0]  stage3;
    logic [63:0] tw3;

    fft32_stage_ctrl #(.LOG2N(5), .TW_AW(4), .BFLY_LAT(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .ready(ready1),
        .abort(abort1), .bf_en(bf1), .wr_en(wr1), .stage(stage1),
        .buf_sel(bs1), .tw_addr(tw1), .busy(busy1),
        .out_valid(ov1), .out_ready(ordy1), .scale_en(sc1)
    );

    fft32_stage_ctrl #(.LOG2N(5), .TW_AW(4), .BFLY_LAT(3)) u3 (
        .clk(clk), .rst(rst), .start(start3), .ready(ready3),
        .abort(abort3), .bf_en(bf3), .wr_en(wr3), .stage(stage3),
        .buf_sel(bs3), .tw_addr(tw3), .busy(busy3),
        .out_valid(ov3), .out_ready(ordy3), .scale_en(sc3)
    );

    int checks = 0;
    int errors = 0;
    int exp_bf[$];
    int exp_wr[$];
    int exp_ov[$];

    function automatic logic [3:0] tw_ref(input int k, input int s);
        return 4'((k % (1 << s)) * (1 << (4 - s)));
    endfunction

    function automatic logic exp_scale(input logic active);
`ifdef FFT_STAGE_SCALE_EN
        return active;
`else
        return 1'b0 & active;
`endif
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [9:0] obs;
        int cyc;
        #12;
        obs = {ready1, bf1, wr1, busy1, ov1, sc1, stage1, bs1};
        checks++;
        if (obs !== 10'b10_0000_0000) begin
            errors++;
            $display("FAIL reset_vec got %b want %b", obs, 10'b10_0000_0000);
        end
        checks++;
        if (tw1 !== 64'd0) begin
            errors++;
            $display("FAIL reset_tw got %h want 0", tw1);
        end
        tick();
        rst = 1'b1;
        tick();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        cyc = 1;
        while (cyc < 6) begin
            tick();
            cyc++;
        end
        checks++;
        if (!(wr1 === 1'b1 && stage1 === 3'd2)) begin
            errors++;
            $display("FAIL pre_rst_wait got wr=%b st=%0d want wr=1 st=2",
                     wr1, stage1);
        end
        #2 rst = 1'b0;
        #1;
        obs = {ready1, bf1, wr1, busy1, ov1, sc1, stage1, bs1};
        checks++;
        if (obs !== 10'b10_0000_0000 || tw1 !== 64'd0) begin
            errors++;
            $display("FAIL midrst_vec got %b tw %h want %b tw 0",
                     obs, tw1, 10'b10_0000_0000);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (ready1 !== 1'b1 || busy1 !== 1'b0) begin
                errors++;
                $display("FAIL rst_ready got %b want 1", ready1);
            end
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_nominal();
        int cyc, e, bfi;
        bit done;
        int ks[4] = '{0, 7, 9, 15};
        logic [3:0] as[4] = '{4'd0, 4'd14, 4'd2, 4'd14};
        for (int s = 0; s < 5; s++) begin
            exp_bf.push_back(1 + 2 * s);
            exp_wr.push_back(2 + 2 * s);
        end
        exp_ov.push_back(11);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        cyc = 1;
        bfi = 0;
        done = 0;
        while (!done && cyc <= 20) begin
            checks++;
            if (sc1 !== exp_scale(cyc <= 10)) begin
                errors++;
                $display("FAIL nom_scale c%0d got %b want %b",
                         cyc, sc1, exp_scale(cyc <= 10));
            end
            if (bf1) begin
                e = (exp_bf.size() > 0) ? exp_bf.pop_front() : -1;
                checks++;
                if (cyc != e) begin
                    errors++;
                    $display("FAIL nom_bf got c%0d want c%0d", cyc, e);
                end
                checks++;
                if (stage1 !== 3'(bfi)) begin
                    errors++;
                    $display("FAIL nom_stage got %0d want %0d", stage1, bfi);
                end
                for (int k = 0; k < 16; k++) begin
                    checks++;
                    if (tw1[k*4 +: 4] !== tw_ref(k, bfi)) begin
                        errors++;
                        $display("FAIL nom_tw s%0d k%0d got %0d want %0d",
                                 bfi, k, tw1[k*4 +: 4], tw_ref(k, bfi));
                    end
                end
                if (bfi == 3) begin
                    for (int j = 0; j < 4; j++) begin
                        checks++;
                        if (tw1[ks[j]*4 +: 4] !== as[j]) begin
                            errors++;
                            $display("FAIL tw_s3 k%0d got %0d want %0d",
                                     ks[j], tw1[ks[j]*4 +: 4], as[j]);
                        end
                    end
                end
                bfi++;
            end
            if (wr1) begin
                e = (exp_wr.size() > 0) ? exp_wr.pop_front() : -1;
                checks++;
                if (cyc != e) begin
                    errors++;
                    $display("FAIL nom_wr got c%0d want c%0d", cyc, e);
                end
            end
            if (ov1) begin
                e = (exp_ov.size() > 0) ? exp_ov.pop_front() : -1;
                checks++;
                if (cyc != e || bs1 !== 1'b1 || stage1 !== 3'd4) begin
                    errors++;
                    $display("FAIL nom_ov got c%0d bs%b st%0d want c%0d bs1 st4",
                             cyc, bs1, stage1, e);
                end
                done = 1;
            end
            if (!done) begin
                tick();
                cyc++;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL nom_timeout got no out_valid want c11");
        end
        checks++;
        if (exp_bf.size() + exp_wr.size() + exp_ov.size() != 0) begin
            errors++;
            $display("FAIL nom_left got %0d pending want 0",
                     exp_bf.size() + exp_wr.size() + exp_ov.size());
        end
        exp_bf.delete();
        exp_wr.delete();
        exp_ov.delete();
        ordy1 = 1'b1;
        tick();
        ordy1 = 1'b0;
        checks++;
        if (ready1 !== 1'b1 || ov1 !== 1'b0) begin
            errors++;
            $display("FAIL nom_hs got rdy%b ov%b want rdy1 ov0", ready1, ov1);
        end
    endtask

    task automatic test_backpressure();
        int n;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 1;
        while (!ov1 && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (ov1 !== 1'b1) begin
            errors++;
            $display("FAIL bp_timeout got ov%b want 1", ov1);
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (ov1 !== 1'b1 || ready1 !== 1'b0 || bf1 !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold i%0d got ov%b rdy%b bf%b want 1 0 0",
                         i, ov1, ready1, bf1);
            end
            start1 = (i == 5);
            tick();
        end
        start1 = 1'b0;
        ordy1 = 1'b1;
        tick();
        ordy1 = 1'b0;
        checks++;
        if (ready1 !== 1'b1 || ov1 !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got rdy%b ov%b want 1 0", ready1, ov1);
        end
        tick();
        checks++;
        if (bf1 !== 1'b0 || ready1 !== 1'b1) begin
            errors++;
            $display("FAIL bp_ignored got bf%b rdy%b want 0 1", bf1, ready1);
        end
    endtask

    task automatic test_abort();
        int cyc, n;
        ordy1 = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        cyc = 1;
        while (!(bf1 && stage1 == 3'd3) && cyc < 20) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc != 7) begin
            errors++;
            $display("FAIL ab_issue3 got c%0d want c7", cyc);
        end
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        checks++;
        if ({ready1, bf1, wr1, ov1} !== 4'b1000) begin
            errors++;
            $display("FAIL ab_next got %b want 1000", {ready1, bf1, wr1, ov1});
        end
        checks++;
        if (stage1 !== 3'd3 || bs1 !== 1'b1) begin
            errors++;
            $display("FAIL ab_keep got st%0d bs%b want st3 bs1", stage1, bs1);
        end
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++;
            if (bf1 | wr1 | ov1) begin
                errors++;
                $display("FAIL ab_quiet i%0d got bf%b wr%b ov%b want 0",
                         i, bf1, wr1, ov1);
            end
        end
        ordy1 = 1'b0;
        abort1 = 1'b1;
        start1 = 1'b1;
        tick();
        abort1 = 1'b0;
        start1 = 1'b0;
        checks++;
        if (ready1 !== 1'b1 || bf1 !== 1'b0) begin
            errors++;
            $display("FAIL ab_start got rdy%b bf%b want 1 0", ready1, bf1);
        end
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        checks++;
        if (bf1 !== 1'b1 || stage1 !== 3'd0 || bs1 !== 1'b0 ||
            tw1 !== 64'd0) begin
            errors++;
            $display("FAIL ab_restart got bf%b st%0d bs%b tw%h want 1 0 0 0",
                     bf1, stage1, bs1, tw1);
        end
        n = 0;
        while (!ov1 && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (ov1 !== 1'b1 || n != 10) begin
            errors++;
            $display("FAIL ab_rerun got ov%b after %0d want ov1 after 10",
                     ov1, n);
        end
        ordy1 = 1'b1;
        tick();
        ordy1 = 1'b0;
    endtask

    task automatic test_lat3();
        int cyc, e;
        bit done;
        for (int s = 0; s < 5; s++) begin
            exp_bf.push_back(1 + 4 * s);
            exp_wr.push_back(4 + 4 * s);
        end
        exp_ov.push_back(21);
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        cyc = 1;
        done = 0;
        while (!done && cyc <= 30) begin
            checks++;
            if (sc3 !== exp_scale(cyc <= 20)) begin
                errors++;
                $display("FAIL l3_scale c%0d got %b want %b",
                         cyc, sc3, exp_scale(cyc <= 20));
            end
            if (bf3) begin
                e = (exp_bf.size() > 0) ? exp_bf.pop_front() : -1;
                checks++;
                if (cyc != e) begin
                    errors++;
                    $display("FAIL l3_bf got c%0d want c%0d", cyc, e);
                end
            end
            if (wr3) begin
                e = (exp_wr.size() > 0) ? exp_wr.pop_front() : -1;
                checks++;
                if (cyc != e) begin
                    errors++;
                    $display("FAIL l3_wr got c%0d want c%0d", cyc, e);
                end
            end
            if (ov3) begin
                e = (exp_ov.size() > 0) ? exp_ov.pop_front() : -1;
                checks++;
                if (cyc != e || bs3 !== 1'b1) begin
                    errors++;
                    $display("FAIL l3_ov got c%0d bs%b want c%0d bs1",
                             cyc, bs3, e);
                end
                done = 1;
            end
            if (!done) begin
                tick();
                cyc++;
            end
        end
        checks++;
        if (!done || exp_bf.size() + exp_wr.size() != 0) begin
            errors++;
            $display("FAIL l3_end got done%b pending %0d want done1 pending 0",
                     done, exp_bf.size() + exp_wr.size());
        end
        exp_bf.delete();
        exp_wr.delete();
        exp_ov.delete();
        ordy3 = 1'b1;
        tick();
        ordy3 = 1'b0;
        checks++;
        if (ready3 !== 1'b1 || ov3 !== 1'b0 || sc3 !== 1'b0) begin
            errors++;
            $display("FAIL l3_hs got rdy%b ov%b sc%b want 1 0 0",
                     ready3, ov3, sc3);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_abort();
        test_lat3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
